prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader upstream of the 14-bit-address / 10-bit-data unified memory. It accepts a length-prefixed word stream over a valid/ready interface and writes it into consecutive memory locations through the memory's write port. The CPU is held off via `cpu_run` until the image is fully written (and, optionally, checksum-verified). After `DONE`, ownership of the memory port returns to the CPU through the top-level mux driven by `busy`.

## Interface
- `BASE_ADDR`, 14'd0, memory address of the first loaded word
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  stream word present on `in_data`
- `in_data`  in  10  stream word
- `in_ready`  out  1  loader accepts a word this cycle
- `restart`  in  1  re-arm the loader from `DONE` or `ERR`
- `m_addr`  out  14  memory address
- `m_indata`  out  10  memory write data
- `m_write`  out  1  memory write enable
- `m_read`  out  1  memory read enable; constant 0
- `busy`  out  1  loader owns the memory port
- `cpu_run`  out  1  CPU may execute; high only in `DONE`
- `error`  out  1  high only in `ERR`
- `words_loaded`  out  14  count of data words written since the last (re)arm

## Operation
- A transfer occurs when `in_valid && in_ready` is high at a rising edge.
- States: `CNT_HI`, `CNT_LO`, `DATA`, `FLUSH`, `CHECK` (only when checksum is enabled), `DONE`, `ERR`.
- `in_ready` is a state decode:
  - high in `CNT_HI`, `CNT_LO`, `DATA`, `CHECK`
  - low in all other states
- `CNT_HI`: on transfer, `len[13:10] = in_data[3:0]` (bits 9:4 ignored), then go to `CNT_LO`.
- `CNT_LO`: on transfer, `len[9:0] = in_data`.
  - `len == 0`: go to `FLUSH`.
  - Otherwise: go to `DATA`.
- `DATA`: on each transfer:
  - register `m_addr = BASE_ADDR + words_loaded` (mod 2^14; wraps 16383→0), `m_indata = in_data`, `m_write = 1` for exactly one cycle.
  - Increment `words_loaded`.
  - Accumulate `sum = (sum + in_data) mod 1024`.
  - After the `len`-th word, go to `FLUSH`.
- `FLUSH`: one cycle; lets the final write commit.
  - Checksum enabled: go to `CHECK`.
  - Otherwise: go to `DONE`.
- `DONE`: `cpu_run = 1`, `busy = 0`. Stays here until `restart`.
- `ERR`: `error = 1`, `cpu_run = 0`, `busy = 0`. Stays here until `restart`.
- `restart` in `DONE` or `ERR`:
  - Next state `CNT_HI`; `words_loaded` and `sum` cleared.
  - `cpu_run` and `error` drop in the same cycle the state changes.
- `restart` in any other state is ignored.
- `busy` is high in `CNT_HI`, `CNT_LO`, `DATA`, `FLUSH`, `CHECK`.
- `in_valid` gaps stall the state machine indefinitely. No timeout.
- `in_data` is ignored when `in_ready` is low.

## Timing
- Reset (async, `rst = 0`) forces:
  - state `CNT_HI`, `m_write = 0`, `m_addr = 0`, `m_indata = 0`, `m_read = 0`
  - `words_loaded = 0`, `sum = 0`, `len = 0`
  - `cpu_run = 0`, `error = 0`, `busy = 1`, `in_ready = 1`
- Reset mid-load abandons the image; already-written memory is not restored.
- Write latency: data accepted at edge k is driven on `m_*` during cycle k+1. Memory captures it at edge k+2.
- One word per cycle sustained. The `m_write` pulses mirror the accepted transfers, delayed by 1 cycle.
- Last data word accepted at edge k:
  - `FLUSH` during cycle k+1 (final `m_write` high).
  - Without checksum: `DONE`/`cpu_run` from edge k+2.
- `len = 0`: `CNT_LO` transfer at edge k, then `FLUSH`, then `DONE` at edge k+2. No write occurs.
- `m_write` is low in every cycle not directly following a `DATA` transfer.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - After `FLUSH`, enter `CHECK` (`in_ready = 1`) and accept one trailer word.
  - Trailer equal to `sum` → `DONE`; otherwise → `ERR`.
  - `DONE` arrives one edge after the trailer transfer.
- Not defined:
  - `CHECK` and the `sum` register are not built; `FLUSH` → `DONE`.
  - `error` is tied to 0; `ERR` is unreachable.

## Test plan
- Stream 0x000, 0x003, 0x001, 0x002, 0x3FF, continuous valid → writes (0,0x001), (1,0x002), (2,0x3FF) on three consecutive cycles; `cpu_run` rises two edges after the last accept; `words_loaded = 3`.
- Stream 0x000, 0x000 → no `m_write`; `cpu_run = 1` two edges after the second accept.
- Same 3-word image with `in_valid` toggling 1/0 every cycle → identical addresses and data; `m_write` pulses spaced 2 cycles apart.
- Assert `rst` after the second data word → all outputs at reset values immediately; the next stream reloads from `BASE_ADDR`.
- With `PROG_LOADER_CHECKSUM_EN`, data 0x3FF, 0x002:
  - trailer 0x001 → `DONE`
  - trailer 0x002 → `ERR`, `error = 1`, `cpu_run = 0`
- In `DONE`, pulse `restart` → `cpu_run` drops next cycle, `in_ready = 1`, `words_loaded = 0`; a new 1-word image loads. With `BASE_ADDR = 16383` and `len = 2`, the addresses written are 16383 then 0.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time program loader: writes a length-prefixed word stream into memory, then releases the CPU.
// Define PROG_LOADER_CHECKSUM_EN to require a trailer word matching the mod-1024 data sum.
module prog_loader #(
  parameter logic [13:0] BASE_ADDR = 14'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [9:0]  in_data,
  output logic        in_ready,
  input  logic        restart,
  output logic [13:0] m_addr,
  output logic [9:0]  m_indata,
  output logic        m_write,
  output logic        m_read,
  output logic        busy,
  output logic        cpu_run,
  output logic        error,
  output logic [13:0] words_loaded
);

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 10;

  typedef enum logic [2:0] {
    S_CNT_HI = 3'd0,
    S_CNT_LO = 3'd1,
    S_DATA   = 3'd2,
    S_FLUSH  = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_len;
  logic [AW-1:0] r_words;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_write;
  logic          r_busy;
  logic          r_ready;
  logic          r_run;
  logic          w_xfer;
  logic          w_last;
  logic [AW-1:0] w_len_full;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DW-1:0] r_sum;
  logic          r_err;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_CNT_HI;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next     = r_state;
    w_xfer     = in_valid && r_ready;
    w_len_full = {r_len[13:10], in_data};
    w_last     = (r_words + AW'(1)) == r_len;
    case (r_state)
      S_CNT_HI: if (w_xfer) w_next = S_CNT_LO;
      S_CNT_LO: if (w_xfer) w_next = (w_len_full == '0) ? S_FLUSH : S_DATA;
      S_DATA:   if (w_xfer && w_last) w_next = S_FLUSH;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_FLUSH:  w_next = S_CHECK;
      S_CHECK:  if (w_xfer) w_next = (in_data == r_sum) ? S_DONE : S_ERR;
`else
      S_FLUSH:  w_next = S_DONE;
`endif
      S_DONE, S_ERR: if (restart) w_next = S_CNT_HI;
      default:  w_next = S_CNT_HI;
    endcase
  end

  // Status flags registered from the next state so they change with the state itself
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy  <= 1'b1;
      r_ready <= 1'b1;
      r_run   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_busy  <= (w_next != S_DONE) && (w_next != S_ERR);
      r_ready <= (w_next == S_CNT_HI) || (w_next == S_CNT_LO) ||
                 (w_next == S_DATA)   || (w_next == S_CHECK);
      r_run   <= (w_next == S_DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
      r_err   <= (w_next == S_ERR);
`endif
    end
  end

  // Length capture, memory write pipeline and word counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len   <= '0;
      r_words <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_write <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      r_write <= 1'b0;
      case (r_state)
        S_CNT_HI: if (w_xfer) r_len[13:10] <= in_data[3:0];
        S_CNT_LO: if (w_xfer) r_len[9:0] <= in_data;
        S_DATA: begin
          if (w_xfer) begin
            r_write <= 1'b1;
            r_addr  <= BASE_ADDR + r_words;
            r_data  <= in_data;
            r_words <= r_words + AW'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum   <= r_sum + in_data;
`endif
          end
        end
        S_DONE, S_ERR: begin
          if (restart) begin
            r_words <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum   <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = r_ready;
  assign busy         = r_busy;
  assign cpu_run      = r_run;
  assign m_addr       = r_addr;
  assign m_indata     = r_data;
  assign m_write      = r_write;
  assign m_read       = 1'b0;
  assign words_loaded = r_words;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign error        = r_err;
`else
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: vector table, hand sequences and random images against a queue-based write model.
// Two instances run in lockstep: base address 0 and base address 16383 (address wrap).
module tb_prog_loader;

  localparam int WRAP_BASE = 16383;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [9:0]  in_data;
  logic        restart;

  logic        a_in_ready, a_m_write, a_m_read, a_busy, a_cpu_run, a_error;
  logic [13:0] a_m_addr, a_words;
  logic [9:0]  a_m_indata;
  logic        b_in_ready, b_m_write, b_m_read, b_busy, b_cpu_run, b_error;
  logic [13:0] b_m_addr, b_words;
  logic [9:0]  b_m_indata;

  prog_loader #(.BASE_ADDR(14'd0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .restart(restart), .m_addr(a_m_addr), .m_indata(a_m_indata), .m_write(a_m_write),
    .m_read(a_m_read), .busy(a_busy), .cpu_run(a_cpu_run), .error(a_error),
    .words_loaded(a_words)
  );

  prog_loader #(.BASE_ADDR(14'd16383)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .restart(restart), .m_addr(b_m_addr), .m_indata(b_m_indata), .m_write(b_m_write),
    .m_read(b_m_read), .busy(b_busy), .cpu_run(b_cpu_run), .error(b_error),
    .words_loaded(b_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected memory writes: the edge after which the pulse must be visible, word index, data
  typedef struct {
    int         edge_n;
    int         idx;
    logic [9:0] data;
  } wr_t;
  wr_t wq[$];

  // Write monitor: every cycle either a due write matches or both write enables are low
  always @(posedge clk) begin : mon
    wr_t e;
    #1;
    if (wq.size() > 0 && wq[0].edge_n == cyc) begin
      e = wq.pop_front();
      chk("m_write", int'(a_m_write), 1);
      chk("wrap m_write", int'(b_m_write), 1);
      chk("m_addr", int'(a_m_addr), e.idx % 16384);
      chk("wrap m_addr", int'(b_m_addr), (WRAP_BASE + e.idx) % 16384);
      chk("m_indata", int'(a_m_indata), int'(e.data));
      chk("wrap m_indata", int'(b_m_indata), int'(e.data));
    end else begin
      chk("m_write idle", int'(a_m_write), 0);
      chk("wrap m_write idle", int'(b_m_write), 0);
    end
    chk("m_read", int'(a_m_read | b_m_read), 0);
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset();
    chk("rst m_write", int'(a_m_write), 0);
    chk("rst m_addr", int'(a_m_addr), 0);
    chk("rst wrap m_addr", int'(b_m_addr), 0);
    chk("rst m_indata", int'(a_m_indata), 0);
    chk("rst m_read", int'(a_m_read), 0);
    chk("rst words_loaded", int'(a_words), 0);
    chk("rst cpu_run", int'(a_cpu_run), 0);
    chk("rst error", int'(a_error), 0);
    chk("rst busy", int'(a_busy), 1);
    chk("rst in_ready", int'(a_in_ready), 1);
  endtask

  // Present one word from a negedge; returns the index of the edge that accepted it
  task automatic send(input logic [9:0] w, input int gap, input bit is_data, input int idx,
                      output int acc);
    int budget;
    wr_t e;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    budget   = 0;
    while (a_in_ready !== 1'b1 && budget < 64) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 64) chk("in_ready timeout", int'(a_in_ready), 1);
    acc = cyc + 1;
    if (is_data) begin
      e.edge_n = acc; e.idx = idx; e.data = w;
      wq.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 10'(($urandom));
  endtask

  // Load one image; gmode 0 = continuous, 1 = alternate cycles, 2 = random gaps
  task automatic load_image(input int len, input logic [9:0] d[$], input int gmode,
                            input bit bad_trailer);
    int acc;
    int g;
    int sum;
    logic [9:0] hi;
    hi  = {6'($urandom), 4'(len >> 10)};
    sum = 0;
    send(hi, 0, 1'b0, 0, acc);
    send(10'(len), (gmode == 1) ? 1 : 0, 1'b0, 0, acc);
    for (int i = 0; i < len; i++) begin
      g = (gmode == 0) ? 0 : (gmode == 1) ? 1 : int'($urandom_range(0, 2));
      send(d[i], g, 1'b1, i, acc);
      sum = (sum + int'(d[i])) % 1024;
    end
    chk("flush busy", int'(a_busy), 1);
    chk("flush in_ready", int'(a_in_ready), 0);
    chk("flush cpu_run", int'(a_cpu_run), 0);
    @(negedge clk);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("check in_ready", int'(a_in_ready), 1);
    chk("check cpu_run", int'(a_cpu_run), 0);
    send(bad_trailer ? 10'(sum + 1) : 10'(sum), 0, 1'b0, 0, acc);
    chk("trailer cpu_run", int'(a_cpu_run), bad_trailer ? 0 : 1);
    chk("trailer error", int'(a_error), bad_trailer ? 1 : 0);
`else
    chk("done cpu_run", int'(a_cpu_run), 1);
    chk("done error", int'(a_error), 0);
`endif
    chk("done busy", int'(a_busy), 0);
    chk("done in_ready", int'(a_in_ready), 0);
    chk("done words_loaded", int'(a_words), len);
    chk("done wrap words_loaded", int'(b_words), len);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("restart cpu_run", int'(a_cpu_run), 0);
    chk("restart error", int'(a_error), 0);
    chk("restart in_ready", int'(a_in_ready), 1);
    chk("restart busy", int'(a_busy), 1);
    chk("restart words_loaded", int'(a_words), 0);
  endtask

  typedef struct {
    int         len;
    int         gmode;
    logic [9:0] d0, d1, d2;
    int         exp_words;
  } vec_t;

  initial begin : main
    vec_t       tbl[5];
    logic [9:0] d[$];
    int         acc;
    int         len;

    rst = 1'b0; in_valid = 1'b0; in_data = '0; restart = 1'b0;
    repeat (2) @(negedge clk);
    check_reset();
    rst = 1'b1;
    @(negedge clk);

    tbl[0] = '{len: 3, gmode: 0, d0: 10'h001, d1: 10'h002, d2: 10'h3FF, exp_words: 3};
    tbl[1] = '{len: 0, gmode: 0, d0: 10'h000, d1: 10'h000, d2: 10'h000, exp_words: 0};
    tbl[2] = '{len: 3, gmode: 1, d0: 10'h001, d1: 10'h002, d2: 10'h3FF, exp_words: 3};
    tbl[3] = '{len: 1, gmode: 0, d0: 10'h155, d1: 10'h000, d2: 10'h000, exp_words: 1};
    tbl[4] = '{len: 2, gmode: 2, d0: 10'h3FF, d1: 10'h002, d2: 10'h000, exp_words: 2};

    for (int i = 0; i < 5; i++) begin
      d = '{tbl[i].d0, tbl[i].d1, tbl[i].d2};
      load_image(tbl[i].len, d, tbl[i].gmode, 1'b0);
      chk("table words_loaded", int'(a_words), tbl[i].exp_words);
      if (i == 0) begin
        // Valid held high with junk while done: nothing may be accepted or written
        in_valid = 1'b1;
        in_data  = 10'h2AA;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("done ignores stream words", int'(a_words), 3);
        chk("done ignores stream run", int'(a_cpu_run), 1);
      end
      do_restart();
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    d = '{10'h3FF, 10'h002};
    load_image(2, d, 0, 1'b1);
    chk("err busy", int'(a_busy), 0);
    do_restart();
`endif

    // Async reset mid-image abandons it; the next image starts again at the base address
    send(10'h000, 0, 1'b0, 0, acc);
    send(10'h003, 0, 1'b0, 0, acc);
    send(10'h111, 0, 1'b1, 0, acc);
    send(10'h222, 0, 1'b1, 1, acc);
    rst = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    d = '{10'h0AB};
    load_image(1, d, 0, 1'b0);
    do_restart();

    // Restart during a load is ignored
    restart = 1'b1;
    send(10'h000, 0, 1'b0, 0, acc);
    send(10'h002, 0, 1'b0, 0, acc);
    send(10'h07F, 0, 1'b1, 0, acc);
    send(10'h300, 0, 1'b1, 1, acc);
    restart = 1'b0;
    chk("restart ignored busy", int'(a_busy), 1);
    @(negedge clk);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(10'h37F, 0, 1'b0, 0, acc);
`endif
    chk("restart ignored run", int'(a_cpu_run), 1);
    chk("restart ignored words", int'(a_words), 2);
    do_restart();

    // Random images, first one long enough to exercise the upper length bits
    for (int n = 0; n < 20; n++) begin
      len = (n == 0) ? 1024 + int'($urandom_range(0, 20)) : int'($urandom_range(0, 12));
      d = {};
      for (int i = 0; i < len; i++) d.push_back(10'($urandom));
      load_image(len, d, 2, 1'($urandom));
      do_restart();
    end

    repeat (2) @(negedge clk);
    chk("pending writes", wq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
